// File: rtl/bru_pkg.sv
// bru_pkg: shared definitions for the SH-4 branch resolution unit.
//   - bru_state_e : sequencer states (IDLE, RESOLVE, WAIT_DS)
//   - bru_class_e : branch class (COND, UNCOND, REG, RET)
//   - bru_tsel_e  : target source select
//   - bru_dec_t   : decoded branch attributes
//   - OP_* / MASK_* : match constants for the twelve branch encodings
//   - bru_decode() : raw instruction word -> bru_dec_t
package bru_pkg;

  typedef enum logic [1:0] {IDLE, RESOLVE, WAIT_DS} bru_state_e;

  typedef enum logic [1:0] {COND, UNCOND, REG, RET} bru_class_e;

  typedef enum logic [1:0] {TGT_ADD, TGT_OPH, TGT_PR, TGT_SPC} bru_tsel_e;

  typedef struct packed {
    logic       known;
    bru_class_e cls;
    logic       delayed;
    logic       link;
    logic       t_sense;
    bru_tsel_e  tsel;
  } bru_dec_t;

  // Field masks: 8-bit displacement, 12-bit displacement, Rn field, exact word.
  localparam logic [15:0] MASK_DISP8  = 16'hFF00;
  localparam logic [15:0] MASK_DISP12 = 16'hF000;
  localparam logic [15:0] MASK_RN     = 16'hF0FF;
  localparam logic [15:0] MASK_FULL   = 16'hFFFF;

  localparam logic [15:0] OP_BT   = 16'h8900;
  localparam logic [15:0] OP_BF   = 16'h8B00;
  localparam logic [15:0] OP_BTS  = 16'h8D00;
  localparam logic [15:0] OP_BFS  = 16'h8F00;
  localparam logic [15:0] OP_BRA  = 16'hA000;
  localparam logic [15:0] OP_BSR  = 16'hB000;
  localparam logic [15:0] OP_BRAF = 16'h0023;
  localparam logic [15:0] OP_BSRF = 16'h0003;
  localparam logic [15:0] OP_JMP  = 16'h402B;
  localparam logic [15:0] OP_JSR  = 16'h400B;
  localparam logic [15:0] OP_RTS  = 16'h000B;
  localparam logic [15:0] OP_RTE  = 16'h002B;

  function automatic bru_dec_t bru_decode(input logic [15:0] raw);
    bru_dec_t d;
    d = '0;
    if ((raw & MASK_DISP8) == OP_BT) begin
      d.known = 1'b1; d.cls = COND; d.t_sense = 1'b1; d.tsel = TGT_ADD;
    end else if ((raw & MASK_DISP8) == OP_BF) begin
      d.known = 1'b1; d.cls = COND; d.t_sense = 1'b0; d.tsel = TGT_ADD;
    end else if ((raw & MASK_DISP8) == OP_BTS) begin
      d.known = 1'b1; d.cls = COND; d.t_sense = 1'b1; d.delayed = 1'b1; d.tsel = TGT_ADD;
    end else if ((raw & MASK_DISP8) == OP_BFS) begin
      d.known = 1'b1; d.cls = COND; d.t_sense = 1'b0; d.delayed = 1'b1; d.tsel = TGT_ADD;
    end else if ((raw & MASK_DISP12) == OP_BRA) begin
      d.known = 1'b1; d.cls = UNCOND; d.delayed = 1'b1; d.tsel = TGT_ADD;
    end else if ((raw & MASK_DISP12) == OP_BSR) begin
      d.known = 1'b1; d.cls = UNCOND; d.delayed = 1'b1; d.link = 1'b1; d.tsel = TGT_ADD;
    end else if ((raw & MASK_RN) == OP_BRAF) begin
      d.known = 1'b1; d.cls = REG; d.delayed = 1'b1; d.tsel = TGT_ADD;
    end else if ((raw & MASK_RN) == OP_BSRF) begin
      d.known = 1'b1; d.cls = REG; d.delayed = 1'b1; d.link = 1'b1; d.tsel = TGT_ADD;
    end else if ((raw & MASK_RN) == OP_JMP) begin
      d.known = 1'b1; d.cls = REG; d.delayed = 1'b1; d.tsel = TGT_OPH;
    end else if ((raw & MASK_RN) == OP_JSR) begin
      d.known = 1'b1; d.cls = REG; d.delayed = 1'b1; d.link = 1'b1; d.tsel = TGT_OPH;
    end else if ((raw & MASK_FULL) == OP_RTS) begin
      d.known = 1'b1; d.cls = RET; d.delayed = 1'b1; d.tsel = TGT_PR;
    end else if ((raw & MASK_FULL) == OP_RTE) begin
      d.known = 1'b1; d.cls = RET; d.delayed = 1'b1; d.tsel = TGT_SPC;
    end
    return d;
  endfunction

endpackage

// File: rtl/bru_ras.sv
// bru_ras: circular return-address stack used for RTS target prediction.
// Only built when BRU_RAS_EN is defined.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears pointer/occupancy)
//   push, push_data   push a return address; a full stack overwrites its oldest entry
//   pop               pop the top entry; ignored when empty
//   top_data          current top-of-stack value (meaningless when empty)
//   empty             no valid entries
`ifdef BRU_RAS_EN
module bru_ras #(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;
  logic          full;

  // ptr names the next free slot, so the top lives one below it.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign top_data = mem[ptr - PW'(1)];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= push_data;
    end
  end

  // Occupancy saturates at DEPTH; the pointer keeps wrapping so the oldest entry is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule
`endif

// File: rtl/bru_seq.sv
// bru_seq: sequential branch resolution unit for the SH-4 execute stage.
// Decodes the branch, resolves direction and target one cycle after accept,
// waits for the delay-slot instruction to retire before redirecting fetch,
// and flags branches issued into a delay slot.
// Optional feature macro: BRU_RAS_EN (return-address stack for RTS prediction).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            branch handshake (ready only in IDLE)
//   in_pc, in_pr, in_spc, in_t   PC, PR, SPC and T flag
//   in_raw, in_opl, in_oph       instruction word and decode-supplied operands
//   ds_done, ds_issue            delay slot retired / instruction issued into slot
//   out_valid, out_taken         result strobe and direction
//   out_target                   redirect address
//   out_write_pr, out_pr_wdata   PR link write for BSR/BSRF/JSR
//   out_redirect                 fetch redirect pulse
//   out_ds_pending               waiting on the delay slot
//   out_slot_illegal             branch-in-delay-slot pulse
//   out_ras_hit                  RTS target matched the stack prediction
module bru_seq
  import bru_pkg::*;
#(
  parameter int AW        = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_pc,
  input  logic [AW-1:0] in_pr,
  input  logic [AW-1:0] in_spc,
  input  logic          in_t,
  input  logic [15:0]   in_raw,
  input  logic [AW-1:0] in_opl,
  input  logic [AW-1:0] in_oph,
  input  logic          ds_done,
  input  logic          ds_issue,
  output logic          out_valid,
  output logic          out_taken,
  output logic [AW-1:0] out_target,
  output logic          out_write_pr,
  output logic [AW-1:0] out_pr_wdata,
  output logic          out_redirect,
  output logic          out_ds_pending,
  output logic          out_slot_illegal,
  output logic          out_ras_hit
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bru_seq: RAS_DEPTH must be a power of two and at least 2");
  end

  bru_state_e    state, state_next;
  bru_dec_t      dec;
  logic          accept;
  logic          taken_now;
  logic          slot_illegal_now;
  logic [AW-1:0] target_now;
  logic [AW-1:0] link_addr;
  logic          ras_hit;

  logic          taken_q, delayed_q, link_q;
  logic          bad_q, redirect_q, illegal_q;
  logic [AW-1:0] target_q, pr_wdata_q;

  assign dec              = bru_decode(in_raw);
  assign accept           = in_valid & (state == IDLE);
  assign link_addr        = in_pc + AW'(4);
  assign slot_illegal_now = (state == WAIT_DS) & in_valid & ds_issue;

  // Direction and target straight from decode; captured only on accept.
  always_comb begin
    target_now = in_opl + in_oph;
    case (dec.tsel)
      TGT_OPH: target_now = in_oph;
      TGT_PR:  target_now = in_pr;
      TGT_SPC: target_now = in_spc;
      default: target_now = in_opl + in_oph;
    endcase
    taken_now = (dec.cls == COND) ? (in_t == dec.t_sense) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A slot-illegal branch in the same cycle as ds_done kills the redirect:
  // the exception takes priority over the branch completing.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q    <= 1'b0;
      delayed_q  <= 1'b0;
      link_q     <= 1'b0;
      target_q   <= '0;
      pr_wdata_q <= '0;
      bad_q      <= 1'b0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      bad_q      <= accept & ~dec.known;
      redirect_q <= (state == WAIT_DS) & ds_done & taken_q & ~slot_illegal_now;
      illegal_q  <= slot_illegal_now;
      if (accept && dec.known) begin
        taken_q    <= taken_now;
        delayed_q  <= dec.delayed;
        link_q     <= dec.link;
        target_q   <= target_now;
        pr_wdata_q <= link_addr;
      end
    end
  end

`ifdef BRU_RAS_EN
  logic          ras_push, ras_pop, ras_empty, ras_hit_q;
  logic [AW-1:0] ras_top;

  assign ras_push = accept & dec.known & dec.link;
  assign ras_pop  = accept & dec.known & (dec.tsel == TGT_PR);

  bru_ras #(
    .AW   (AW),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(link_addr),
    .top_data (ras_top),
    .empty    (ras_empty)
  );

  // The prediction is compared before the pop takes effect; an empty stack never hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_hit_q <= 1'b0;
    end else if (accept) begin
      ras_hit_q <= ras_pop & ~ras_empty & (ras_top == in_pr);
    end
  end

  assign ras_hit = ras_hit_q;
`else
  assign ras_hit = 1'b0;
`endif

  // Unknown opcodes never leave IDLE; their result strobe comes from bad_q.
  // The delayed redirect is registered, so it lands in IDLE after ds_done.
  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    out_valid      = bad_q;
    out_taken      = redirect_q & taken_q;
    out_write_pr   = 1'b0;
    out_redirect   = redirect_q;
    out_ds_pending = 1'b0;
    out_ras_hit    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && dec.known) begin
          state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        out_valid    = 1'b1;
        out_taken    = taken_q;
        out_write_pr = link_q;
        out_ras_hit  = ras_hit;
        out_redirect = ~delayed_q & taken_q;
        state_next   = delayed_q ? WAIT_DS : IDLE;
      end
      WAIT_DS: begin
        out_ds_pending = 1'b1;
        out_taken      = taken_q;
        if (ds_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_target       = target_q;
  assign out_pr_wdata     = pr_wdata_q;
  assign out_slot_illegal = illegal_q;

endmodule

// File: tb/tb_bru_seq.sv
// tb_bru_seq: scoreboard bench for bru_seq.
// Stimulus pushes hand-computed expected results; a negedge monitor pops them
// whenever the DUT strobes out_valid or a delayed out_redirect.
module tb_bru_seq;

`ifdef BRU_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_pr = '0, in_spc = '0, in_opl = '0, in_oph = '0;
  logic        in_t = 1'b0;
  logic [15:0] in_raw = '0;
  logic        ds_done = 1'b0, ds_issue = 1'b0;
  logic        out_valid, out_taken, out_write_pr, out_redirect;
  logic        out_ds_pending, out_slot_illegal, out_ras_hit;
  logic [31:0] out_target, out_pr_wdata;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        chk_target;
    logic        wpr;
    logic [31:0] wdata;
    logic        hit;
    logic        redirect;
  } exp_t;

  exp_t        valid_q[$];
  logic [31:0] redir_q[$];
  int          illegal_exp = 0;
  int          checks = 0;
  int          errors = 0;

  bru_seq #(.AW(32), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pr(in_pr), .in_spc(in_spc), .in_t(in_t),
    .in_raw(in_raw), .in_opl(in_opl), .in_oph(in_oph),
    .ds_done(ds_done), .ds_issue(ds_issue),
    .out_valid(out_valid), .out_taken(out_taken), .out_target(out_target),
    .out_write_pr(out_write_pr), .out_pr_wdata(out_pr_wdata),
    .out_redirect(out_redirect), .out_ds_pending(out_ds_pending),
    .out_slot_illegal(out_slot_illegal), .out_ras_hit(out_ras_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] run did not terminate");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input logic taken, input logic [31:0] target, input logic chk,
                                 input logic wpr, input logic [31:0] wdata, input logic hit,
                                 input logic redirect);
    exp_t e;
    e.taken = taken; e.target = target; e.chk_target = chk; e.wpr = wpr;
    e.wdata = wdata; e.hit = hit; e.redirect = redirect;
    return e;
  endfunction

  // Monitor: every result strobe or delayed redirect must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (valid_q.size() == 0) begin
          checkOutput("unexpected_valid", out_valid, 0);
        end else begin
          exp_t e;
          e = valid_q.pop_front();
          checkOutput("taken", out_taken, e.taken);
          if (e.chk_target) checkOutput("target", out_target, e.target);
          checkOutput("write_pr", out_write_pr, e.wpr);
          if (e.wpr) checkOutput("pr_wdata", out_pr_wdata, e.wdata);
          checkOutput("ras_hit", out_ras_hit, e.hit);
          checkOutput("redirect_now", out_redirect, e.redirect);
        end
      end else if (out_redirect) begin
        if (redir_q.size() == 0) checkOutput("unexpected_redirect", out_redirect, 0);
        else checkOutput("redirect_target", out_target, redir_q.pop_front());
      end
      if (out_slot_illegal && illegal_exp == 0) begin
        checkOutput("unexpected_illegal", out_slot_illegal, 0);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] raw, input logic [31:0] pc, input logic [31:0] opl,
                               input logic [31:0] oph, input logic [31:0] pr, input logic [31:0] spc,
                               input logic t, input exp_t e);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("in_ready_wait", in_ready, 1);
    in_raw = raw; in_pc = pc; in_opl = opl; in_oph = oph;
    in_pr = pr; in_spc = spc; in_t = t; in_valid = 1'b1;
    valid_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("result_latency", out_valid, 1);
  endtask

  task automatic runBranch(input logic [15:0] raw, input logic [31:0] pc, input logic [31:0] opl,
                           input logic [31:0] oph, input logic [31:0] pr, input logic [31:0] spc,
                           input logic t, input logic taken, input logic [31:0] target,
                           input logic wpr, input logic delayed, input logic hit);
    applyStimulus(raw, pc, opl, oph, pr, spc, t,
                  mkExp(taken, target, 1'b1, wpr, pc + 32'd4, hit, taken & ~delayed));
    if (delayed) begin
      @(posedge clk); #1;
      checkOutput("ds_pending", out_ds_pending, 1);
      ds_done = 1'b1;
      if (taken) redir_q.push_back(target);
      @(posedge clk); #1;
      ds_done = 1'b0;
      checkOutput("ds_pending_clear", out_ds_pending, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_redirect", out_redirect, 0);
    checkOutput("reset_pending", out_ds_pending, 0);
    checkOutput("reset_target", out_target, 0);
    checkOutput("reset_illegal", out_slot_illegal, 0);
    checkOutput("reset_ras_hit", out_ras_hit, 0);

    $display("[TB] ds_done in IDLE is ignored");
    ds_done = 1'b1;
    @(posedge clk); #1;
    ds_done = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_ds_done_redirect", out_redirect, 0);

    $display("[TB] conditional branches");
    runBranch(16'h8905, 32'h2000, 32'h1000, 32'h20, 0, 0, 1'b1, 1'b1, 32'h1020, 0, 0, 0);
    runBranch(16'h8B10, 32'h3000, 32'h3004, 32'h40, 0, 0, 1'b1, 1'b0, 32'h3044, 0, 0, 0);
    runBranch(16'h8B10, 32'h3000, 32'h3004, 32'h40, 0, 0, 1'b0, 1'b1, 32'h3044, 0, 0, 0);
    runBranch(16'h8D02, 32'h5000, 32'h5004, 32'h4, 0, 0, 1'b0, 1'b0, 32'h5008, 0, 1, 0);
    runBranch(16'h8F03, 32'h6000, 32'h6004, 32'h6, 0, 0, 1'b0, 1'b1, 32'h600A, 0, 1, 0);

    $display("[TB] BRA with three delay-slot cycles");
    applyStimulus(16'hA123, 32'h4000, 32'h4004, 32'h246, 0, 0, 1'b0,
                  mkExp(1'b1, 32'h424A, 1'b1, 1'b0, 32'h4004, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("bra_ds_pending", out_ds_pending, 1);
      checkOutput("bra_no_early_redirect", out_redirect, 0);
      if (i == 2) begin
        ds_done = 1'b1;
        redir_q.push_back(32'h424A);
      end
    end
    @(posedge clk); #1;
    ds_done = 1'b0;
    checkOutput("bra_redirect", out_redirect, 1);
    checkOutput("bra_pending_clear", out_ds_pending, 0);

    $display("[TB] register and return branches");
    runBranch(16'h410B, 32'h8C000100, 32'h8C000104, 32'h8C002000, 0, 0, 1'b0,
              1'b1, 32'h8C002000, 1, 1, 0);
    runBranch(16'h000B, 32'h8C002000, 0, 0, 32'h8C000104, 0, 1'b0,
              1'b1, 32'h8C000104, 0, 1, RAS_ON);
    runBranch(16'h002B, 32'h8C002100, 0, 0, 32'h11111110, 32'h8C000600, 1'b0,
              1'b1, 32'h8C000600, 0, 1, 0);
    runBranch(16'h0323, 32'h7000, 32'h100, 32'hFFFFFFF0, 0, 0, 1'b0, 1'b1, 32'hF0, 0, 1, 0);
    runBranch(16'h0503, 32'h7000, 32'h7004, 32'h200, 0, 0, 1'b0, 1'b1, 32'h7204, 1, 1, 0);
    runBranch(16'h432B, 32'h7100, 32'h7104, 32'h9000, 0, 0, 1'b0, 1'b1, 32'h9000, 0, 1, 0);
    runBranch(16'hB010, 32'h2000, 32'h2004, 32'h20, 0, 0, 1'b0, 1'b1, 32'h2024, 1, 1, 0);

    $display("[TB] unknown opcode");
    applyStimulus(16'h0009, 32'h2200, 32'h2204, 32'h10, 0, 0, 1'b1,
                  mkExp(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    checkOutput("unknown_stays_idle", in_ready, 1);

    $display("[TB] branch in delay slot with simultaneous ds_done");
    applyStimulus(16'hA010, 32'h8000, 32'h8004, 32'h20, 0, 0, 1'b0,
                  mkExp(1'b1, 32'h8024, 1'b1, 1'b0, 32'h8004, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_raw = 16'hB005; in_pc = 32'h8024; in_valid = 1'b1; ds_issue = 1'b1; ds_done = 1'b1;
    illegal_exp = 1;
    @(posedge clk); #1;
    in_valid = 1'b0; ds_issue = 1'b0; ds_done = 1'b0;
    checkOutput("slot_illegal", out_slot_illegal, 1);
    checkOutput("illegal_no_redirect", out_redirect, 0);
    checkOutput("illegal_no_write_pr", out_write_pr, 0);
    checkOutput("illegal_to_idle", in_ready, 1);
    @(negedge clk); #1;
    illegal_exp = 0;

    $display("[TB] branch in delay slot, held target survives");
    applyStimulus(16'hA011, 32'h8100, 32'h8104, 32'h30, 0, 0, 1'b0,
                  mkExp(1'b1, 32'h8134, 1'b1, 1'b0, 32'h8104, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_raw = 16'h400B; in_oph = 32'hDEAD0000; in_valid = 1'b1; ds_issue = 1'b1;
    illegal_exp = 1;
    @(posedge clk); #1;
    in_valid = 1'b0; ds_issue = 1'b0;
    checkOutput("slot_illegal_wait", out_slot_illegal, 1);
    checkOutput("still_pending", out_ds_pending, 1);
    @(negedge clk); #1;
    illegal_exp = 0;
    ds_done = 1'b1;
    redir_q.push_back(32'h8134);
    @(posedge clk); #1;
    ds_done = 1'b0;
    checkOutput("held_redirect", out_redirect, 1);

    $display("[TB] reset during WAIT_DS");
    applyStimulus(16'hA012, 32'h9000, 32'h9004, 32'h8, 0, 0, 1'b0,
                  mkExp(1'b1, 32'h900C, 1'b1, 1'b0, 32'h9004, 1'b0, 1'b0));
    @(posedge clk); #1;
    checkOutput("pre_reset_pending", out_ds_pending, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("post_reset_ready", in_ready, 1);
    checkOutput("post_reset_pending", out_ds_pending, 0);
    ds_done = 1'b1;
    @(posedge clk); #1;
    ds_done = 1'b0;
    checkOutput("post_reset_no_redirect", out_redirect, 0);

    $display("[TB] return-address stack overflow and underflow");
    for (int i = 0; i < 5; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(i) * 32'h100;
      runBranch(16'hB008, pc, pc + 32'd4, 32'h10, 0, 0, 1'b0, 1'b1, pc + 32'h14, 1, 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      logic [31:0] pr;
      pr = 32'h1404 - 32'(i) * 32'h100;
      runBranch(16'h000B, 32'h3000, 0, 0, pr, 0, 1'b0, 1'b1, pr, 0, 1, RAS_ON && (i < 4));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("valid_queue_drained", valid_q.size(), 0);
    checkOutput("redirect_queue_drained", redir_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
